// File: rtl/seq_multiplier.sv
// seq_multiplier: multicycle unsigned shift-add multiplier.
// Takes two Nbits operands on START and produces a 2*Nbits product and a
// zero flag after Nbits iterations, using one 2*Nbits-wide adder.
// Optional feature macro: ZERO_SKIP_EN. When it is defined, a zero operand
// completes in one cycle and BUSY stays low.
//
// Handshake: START is a request sampled on each rising clk edge. It is
// accepted only in IDLE or FIN; it is ignored while BUSY is high. BUSY is
// high for the whole RUN phase. DONE is a one-cycle pulse in the cycle where
// RESULT/FLAG_ZERO have just been updated. There is no backpressure: the
// result must be taken while DONE is high, or later from the held RESULT.
module seq_multiplier #(
  parameter int Nbits = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               START,
  input  logic [Nbits-1:0]   A,
  input  logic [Nbits-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*Nbits-1:0] RESULT,
  output logic               FLAG_ZERO,
  output logic [1:0]         state_dbg
);

  localparam int PW    = 2 * Nbits;
  localparam int CNT_W = $clog2(Nbits) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [Nbits-1:0] mplr;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc_next;

  assign state_dbg = state;

  // Accumulator value after this cycle's conditional add.
  always_comb begin
    acc_next = acc;
    if (mplr[0]) acc_next = acc + mcand;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RESULT    <= '0;
      FLAG_ZERO <= 1'b1;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            mcand <= {{Nbits{1'b0}}, A};
            mplr  <= B;
            acc   <= '0;
            cnt   <= '0;
`ifdef ZERO_SKIP_EN
            if (A == '0 || B == '0) begin
              // The product is known to be zero; skip the iterations.
              state     <= FIN;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              RESULT    <= '0;
              FLAG_ZERO <= 1'b1;
            end else begin
              state <= RUN;
              BUSY  <= 1'b1;
              DONE  <= 1'b0;
            end
`else
            state <= RUN;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
`endif
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
          end
        end

        RUN: begin
          // START is deliberately not looked at here.
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state     <= FIN;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            RESULT    <= acc_next;
            FLAG_ZERO <= (acc_next == '0);
          end
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier (Nbits = 4).
module tb_seq_multiplier;

  localparam int N  = 4;
  localparam int PW = 2 * N;
  localparam int W  = PW + 1;

  logic          clk;
  logic          rst;
  logic          START;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          BUSY;
  logic          DONE;
  logic [PW-1:0] RESULT;
  logic          FLAG_ZERO;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entries: {expected RESULT, expected FLAG_ZERO}.
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [PW-1:0] res;
    logic          zf;
  } vec_t;

  vec_t vecs[8];

  seq_multiplier #(.Nbits(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .START     (START),
    .A         (A),
    .B         (B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .FLAG_ZERO (FLAG_ZERO),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("result", 64'(RESULT), 64'(e[W-1:1]));
        check("flag_zero", 64'(FLAG_ZERO), 64'(e[0]));
        check("busy_at_done", 64'(BUSY), 64'd0);
      end
    end
  end

  // Cycles between an accepting edge and DONE (DONE in the cycle right after
  // the accepting edge counts as 0). All-zero-skip operations give 0.
  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef ZERO_SKIP_EN
    if (a == 0 || b == 0) return 0;
`endif
    return N;
  endfunction

  // Driver: present operands with a one-cycle START pulse.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [PW-1:0] res, input logic zf, input bit push);
    @(negedge clk);
    A = a;
    B = b;
    START = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back({res, zf});
    #1 START = 1'b0;
  endtask

  // Wait for DONE (bounded), counting idle cycles before it and BUSY cycles.
  task automatic wait_done(output int lat, output int busy_cnt);
    bit found;
    found = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (DONE) found = 1'b1;
      else begin
        lat++;
        if (BUSY) busy_cnt++;
      end
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_seen;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  res: 8'h0F, zf: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd15, res: 8'hE1, zf: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  res: 8'h00, zf: 1'b1};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  res: 8'h00, zf: 1'b1};
    vecs[4] = '{a: 4'd6,  b: 4'd7,  res: 8'h2A, zf: 1'b0};
    vecs[5] = '{a: 4'd1,  b: 4'd1,  res: 8'h01, zf: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd1,  res: 8'h0F, zf: 1'b0};
    vecs[7] = '{a: 4'd8,  b: 4'd2,  res: 8'h10, zf: 1'b0};

    rst = 1'b1;
    START = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_result", 64'(RESULT), 64'd0);
    check("rst_flag_zero", 64'(FLAG_ZERO), 64'd1);
    rst = 1'b0;

    // Table-driven operations
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zf, 1'b1);
      wait_done(lat, busy_cnt);
      check("latency", 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
      check("busy_cycles", 64'(busy_cnt), 64'(exp_lat(vecs[i].a, vecs[i].b)));
      repeat (2) @(negedge clk);
      check("result_hold", 64'(RESULT), 64'(vecs[i].res));
      check("done_pulse", 64'(DONE), 64'd0);
    end

    // START held high: 15*15, then 2*7 accepted in FIN.
    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    START = 1'b1;
    @(posedge clk);
    exp_q.push_back({8'hE1, 1'b0});
    @(negedge clk);
    A = 4'd2;
    B = 4'd7;
    wait_done(lat, busy_cnt);
    check("held_first_latency", 64'(lat), 64'(N - 1));
    @(posedge clk);
    exp_q.push_back({8'h0E, 1'b0});
    #1 START = 1'b0;
    wait_done(lat, busy_cnt);
    check("held_second_latency", 64'(lat), 64'(N));

    // START during RUN is ignored; operands are not resampled.
    issue(4'd6, 4'd7, 8'h2A, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    A = 4'd1;
    B = 4'd1;
    START = 1'b1;
    @(posedge clk);
    #1 START = 1'b0;
    wait_done(lat, busy_cnt);
    check("ignored_start_latency", 64'(lat), 64'(N - 2));
    repeat (N + 3) @(negedge clk);
    check("ignored_start_no_extra", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-RUN discards the operation.
    issue(4'd6, 4'd7, 8'h2A, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_busy", 64'(BUSY), 64'd0);
    check("midrun_rst_done", 64'(DONE), 64'd0);
    check("midrun_rst_result", 64'(RESULT), 64'd0);
    check("midrun_rst_flag_zero", 64'(FLAG_ZERO), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (DONE) done_seen++;
    end
    check("midrun_rst_no_done", 64'(done_seen), 64'd0);
    issue(4'd6, 4'd7, 8'h2A, 1'b0, 1'b1);
    wait_done(lat, busy_cnt);
    check("after_rst_latency", 64'(lat), 64'(N));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
